// File: rtl/dp_if.sv
// Datapath control/data bundle: control and operand inputs in, buses and zero flag out.
interface dp_if #(
  parameter int unsigned BUS_WIDTH = 16
);
  logic                 regWrite;
  logic [2:0]           rsA;
  logic [2:0]           rsB;
  logic [2:0]           rd;
  logic [2:0]           constant_in;
  logic                 MB;
  logic                 MD;
  logic [3:0]           op_select;
  logic [BUS_WIDTH-1:0] data_in;
  logic [BUS_WIDTH-1:0] address_out;
  logic [BUS_WIDTH-1:0] data_out;
  logic                 zero;

  modport master (
    output regWrite, rsA, rsB, rd, constant_in, MB, MD, op_select, data_in,
    input  address_out, data_out, zero
  );

  modport slave (
    input  regWrite, rsA, rsB, rd, constant_in, MB, MD, op_select, data_in,
    output address_out, data_out, zero
  );
endinterface

// File: rtl/dp_top.sv
// Single-cycle datapath: 8-entry register file, operand muxes and a combinational
// execution unit whose result (or external load data) is written back on the clock edge.
module dp_top #(
  parameter int unsigned BUS_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  dp_if.slave bus
);
  logic [BUS_WIDTH-1:0] r_rf [8];
  logic [BUS_WIDTH-1:0] rf_EU_A;
  logic [BUS_WIDTH-1:0] rf_MB;
  logic [BUS_WIDTH-1:0] w_bus_b;
  logic [BUS_WIDTH-1:0] w_const;
  logic [BUS_WIDTH-1:0] EU_out;
  logic [BUS_WIDTH-1:0] bus_D;

  assign rf_EU_A = r_rf[bus.rsA];
  assign rf_MB   = r_rf[bus.rsB];
  assign w_const = {{(BUS_WIDTH-3){1'b0}}, bus.constant_in};
  assign w_bus_b = bus.MB ? w_const : rf_MB;

  always_comb begin
    EU_out = '0;
    case (bus.op_select)
      4'b0000: EU_out = rf_EU_A;
      4'b0001: EU_out = rf_EU_A + BUS_WIDTH'(1);
      4'b0010: EU_out = rf_EU_A + w_bus_b;
      4'b0011: EU_out = rf_EU_A + w_bus_b + BUS_WIDTH'(1);
      4'b0100: EU_out = rf_EU_A + ~w_bus_b;
      4'b0101: EU_out = rf_EU_A + ~w_bus_b + BUS_WIDTH'(1);
      4'b0110: EU_out = rf_EU_A - BUS_WIDTH'(1);
      4'b0111: EU_out = rf_EU_A;
      4'b1000: EU_out = rf_EU_A & w_bus_b;
      4'b1001: EU_out = rf_EU_A | w_bus_b;
      4'b1010: EU_out = rf_EU_A ^ w_bus_b;
      4'b1011: EU_out = ~rf_EU_A;
      4'b1100: EU_out = w_bus_b;
      4'b1101: EU_out = w_bus_b >> 1;
      4'b1110: EU_out = w_bus_b << 1;
      4'b1111: EU_out = w_bus_b;
      default: EU_out = '0;
    endcase
  end

  assign bus_D = bus.MD ? bus.data_in : EU_out;

  // Reset wins over regWrite, so a write pending in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
    end else if (bus.regWrite) begin
      r_rf[bus.rd] <= bus_D;
    end
  end

  assign bus.address_out = rf_EU_A;
  assign bus.data_out    = w_bus_b;
  assign bus.zero        = (EU_out == '0);
endmodule

// File: tb/tb_dp_top.sv
// Directed self-checking bench for dp_top with hand-computed expected values.
module tb_dp_top;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  dp_if #(.BUS_WIDTH(16)) bus ();

  dp_top #(.BUS_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [2:0] idx, input logic [15:0] exp, input string tag);
    bus.regWrite = 1'b0;
    bus.rsA      = idx;
    #1;
    check(tag, bus.address_out, exp);
  endtask

  // Execute one EU op and write the result to rd.
  task automatic exec(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                      input logic mb, input logic [2:0] c, input logic [2:0] rd);
    bus.op_select   = op;
    bus.rsA         = a;
    bus.rsB         = b;
    bus.MB          = mb;
    bus.constant_in = c;
    bus.MD          = 1'b0;
    bus.rd          = rd;
    bus.regWrite    = 1'b1;
    tick();
    bus.regWrite    = 1'b0;
  endtask

  task automatic load(input logic [2:0] rd, input logic [15:0] val);
    bus.MD       = 1'b1;
    bus.data_in  = val;
    bus.rd       = rd;
    bus.regWrite = 1'b1;
    tick();
    bus.regWrite = 1'b0;
    bus.MD       = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.regWrite = 1'b0; bus.rsA = 3'd0; bus.rsB = 3'd0; bus.rd = 3'd0;
    bus.constant_in = 3'd0; bus.MB = 1'b0; bus.MD = 1'b0;
    bus.op_select = 4'b0000; bus.data_in = 16'h0000;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_addr", bus.address_out, 16'h0000);
    check("rst_data", bus.data_out, 16'h0000);
    check("rst_zero", 16'(bus.zero), 16'h0001);

    // Wrap-around: 0000-1 and FFFF+1
    exec(4'b0110, 3'd0, 3'd0, 1'b0, 3'd0, 3'd1);
    read_reg(3'd1, 16'hFFFF, "dec_wrap");
    bus.op_select = 4'b0001;
    #1;
    check("inc_wrap_zero", 16'(bus.zero), 16'h0001);
    exec(4'b0001, 3'd1, 3'd0, 1'b0, 3'd0, 3'd1);
    read_reg(3'd1, 16'h0000, "inc_wrap");

    for (int i = 0; i < 8; i++) load(3'(i), 16'hF000 + 16'(i));
    for (int i = 0; i < 8; i++) read_reg(3'(i), 16'hF000 + 16'(i), $sformatf("load_r%0d", i));

    bus.MB = 1'b1; bus.constant_in = 3'd5;
    #1;
    check("busb_const", bus.data_out, 16'h0005);
    bus.MB = 1'b0; bus.rsB = 3'd6;
    #1;
    check("busb_reg", bus.data_out, 16'hF006);

    exec(4'b1100, 3'd0, 3'd0, 1'b1, 3'd7, 3'd2);
    read_reg(3'd2, 16'h0007, "const_r2");
    exec(4'b0010, 3'd1, 3'd0, 1'b1, 3'd7, 3'd0);
    read_reg(3'd0, 16'hF008, "adi_r0");

    // Arithmetic, results to r6: r1=F001 r2=0007 r3=F003 r7=F007
    exec(4'b0000, 3'd1, 3'd0, 1'b0, 3'd0, 3'd6); read_reg(3'd6, 16'hF001, "mova");
    exec(4'b0001, 3'd1, 3'd0, 1'b0, 3'd0, 3'd6); read_reg(3'd6, 16'hF002, "inc");
    exec(4'b0010, 3'd2, 3'd3, 1'b0, 3'd0, 3'd6); read_reg(3'd6, 16'hF00A, "add");
    exec(4'b0011, 3'd2, 3'd3, 1'b0, 3'd0, 3'd6); read_reg(3'd6, 16'hF00B, "add_c");
    exec(4'b0100, 3'd2, 3'd3, 1'b0, 3'd0, 3'd6); read_reg(3'd6, 16'h1003, "add_nb");
    exec(4'b0101, 3'd2, 3'd3, 1'b0, 3'd0, 3'd6); read_reg(3'd6, 16'h1004, "sub");
    exec(4'b0110, 3'd7, 3'd0, 1'b0, 3'd0, 3'd6); read_reg(3'd6, 16'hF006, "dec");
    exec(4'b0111, 3'd3, 3'd0, 1'b0, 3'd0, 3'd6); read_reg(3'd6, 16'hF003, "tsf_a");

    // Logic/shift: r4=F004 r5=F005 r7=F007
    exec(4'b1000, 3'd4, 3'd5, 1'b0, 3'd0, 3'd6); read_reg(3'd6, 16'hF004, "and");
    exec(4'b1001, 3'd4, 3'd5, 1'b0, 3'd0, 3'd6); read_reg(3'd6, 16'hF005, "or");
    exec(4'b1010, 3'd4, 3'd5, 1'b0, 3'd0, 3'd6); read_reg(3'd6, 16'h0001, "xor");
    exec(4'b1011, 3'd5, 3'd0, 1'b0, 3'd0, 3'd6); read_reg(3'd6, 16'h0FFA, "not");
    exec(4'b1100, 3'd0, 3'd7, 1'b0, 3'd0, 3'd6); read_reg(3'd6, 16'hF007, "movb");
    exec(4'b1101, 3'd0, 3'd7, 1'b0, 3'd0, 3'd6); read_reg(3'd6, 16'h7803, "shr");
    exec(4'b1110, 3'd0, 3'd7, 1'b0, 3'd0, 3'd6); read_reg(3'd6, 16'hE00E, "shl");
    exec(4'b1111, 3'd0, 3'd3, 1'b0, 3'd0, 3'd6); read_reg(3'd6, 16'hF003, "tsf_b");

    // Zero flag with regWrite=0 and MD=1: register file must stay intact
    bus.op_select = 4'b1010; bus.rsA = 3'd4; bus.rsB = 3'd4; bus.MB = 1'b0;
    bus.MD = 1'b1; bus.data_in = 16'h1234; bus.rd = 3'd4; bus.regWrite = 1'b0;
    #1;
    check("zero_xor", 16'(bus.zero), 16'h0001);
    tick();
    bus.MD = 1'b0;
    read_reg(3'd4, 16'hF004, "nowrite_r4");

    // Read-during-write: old value before the edge, new value after
    bus.op_select = 4'b0001; bus.rsA = 3'd5; bus.rd = 3'd5; bus.regWrite = 1'b1;
    #1;
    check("rdw_old", bus.address_out, 16'hF005);
    check("rdw_nzero", 16'(bus.zero), 16'h0000);
    tick();
    bus.regWrite = 1'b0;
    check("rdw_new", bus.address_out, 16'hF006);

    // Reset with a pending write
    bus.MD = 1'b1; bus.data_in = 16'h1234; bus.rd = 3'd3; bus.regWrite = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.regWrite = 1'b0; bus.MD = 1'b0;
    for (int i = 0; i < 8; i++) read_reg(3'(i), 16'h0000, $sformatf("rst_r%0d", i));
    tick();
    read_reg(3'd3, 16'h0000, "post_rst_r3");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
